window_conv: RTL and testbench

- Consumes the packed WIN_SIZE x WIN_SIZE pixel window produced by the window buffer stage.
- Computes a per-component 2-D convolution with signed programmable coefficients.
- Normalises, rounds and clamps each component, then emits one output pixel per window on an AXI4-Stream video interface.
- Fully pipelined at one window per clock, with backpressure-driven stall.

---
 rtl/window_conv_if.sv | 13 +
 rtl/window_conv.sv | 198 +++++++++++++++++++
 tb/tb_window_conv.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/window_conv_if.sv
// rtl/window_conv_if.sv - AXI4-Stream bundle (tdata/tvalid/tready/tlast/tuser) used by window_conv
interface axi4_stream_if #(
    parameter int DW = 32
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/window_conv.sv
// rtl/window_conv.sv - pipelined per-component 2-D window convolution; optional bypass via `WINDOW_CONV_BYPASS_EN
module window_conv #(
    parameter int WIN_SIZE      = 5,
    parameter int PX_WIDTH      = 30,
    parameter int COMP_WIDTH    = 10,
    parameter int COMP_CNT      = 3,
    parameter int COEF_WIDTH    = 8,
    parameter int NORM_SHIFT    = 8,
    parameter int TDATA_WIDTH_O = 32
) (
    input  logic                                     clk_i,
    input  logic                                     rstn_i,
    input  logic [WIN_SIZE*WIN_SIZE*COEF_WIDTH-1:0]  coef_i,
`ifdef WINDOW_CONV_BYPASS_EN
    input  logic                                     bypass_i,
`endif
    axi4_stream_if.slave                             window_i,
    axi4_stream_if.master                            video_o
);

    localparam int N   = WIN_SIZE * WIN_SIZE;
    localparam int L   = $clog2(N);
    localparam int CTR = (WIN_SIZE / 2) * WIN_SIZE + (WIN_SIZE / 2);

    // Internal coefficient width is widened so the identity reset kernel
    // (centre = 1<<NORM_SHIFT) is representable even when it exceeds the
    // signed range of COEF_WIDTH. External coefficients are sign-extended.
    localparam int CW     = (NORM_SHIFT + 2 > COEF_WIDTH) ? NORM_SHIFT + 2 : COEF_WIDTH;
    localparam int PROD_W = COMP_WIDTH + 1 + CW;
    localparam int ACC_W  = PROD_W + L;
    localparam int SUM_W  = ACC_W + 1;

    localparam logic signed [CW-1:0]    COEF_ONE = CW'(2 ** NORM_SHIFT);
    localparam logic signed [SUM_W-1:0] RND      = SUM_W'(2 ** (NORM_SHIFT - 1));
    localparam logic signed [SUM_W-1:0] MAXS     = SUM_W'((2 ** COMP_WIDTH) - 1);

    // Number of nodes at adder-tree level l (level 0 = the N products).
    function automatic int lvl_cnt(input int l);
        int c;
        c = N;
        for (int k = 0; k < l; k++) c = (c + 1) / 2;
        return c;
    endfunction

    // Offset of level l (l >= 1) inside the flattened tree storage.
    function automatic int lvl_off(input int l);
        int o;
        o = 0;
        for (int k = 1; k < l; k++) o = o + lvl_cnt(k);
        return o;
    endfunction

    localparam int TREE_NODES = lvl_off(L + 1);
    localparam int ROOT       = lvl_off(L);

    // Round half up, arithmetic shift, then clamp to the unsigned component range.
    function automatic logic [COMP_WIDTH-1:0] norm_clamp(input logic signed [ACC_W-1:0] s);
        logic signed [SUM_W-1:0] r;
        r = (SUM_W'(s) + RND) >>> NORM_SHIFT;
        if (r[SUM_W-1]) begin
            return '0;
        end else if (r > MAXS) begin
            return '1;
        end else begin
            return r[COMP_WIDTH-1:0];
        end
    endfunction

    logic                     en;
    logic                     accept;
    logic                     coef_load;
    logic signed [CW-1:0]     coef_q   [N];
    logic signed [CW-1:0]     coef_sel [N];
    logic signed [PROD_W-1:0] prod_q   [COMP_CNT][N];
    logic signed [ACC_W-1:0]  node_q   [COMP_CNT][TREE_NODES];
    logic [L:0]               vld_q;
    logic [L:0]               last_q;
    logic [L:0]               user_q;
    logic [TDATA_WIDTH_O-1:0] out_d;
`ifdef WINDOW_CONV_BYPASS_EN
    logic [L:0]               byp_q;
    logic [PX_WIDTH-1:0]      ctr_q [L+1];
`endif

    assign en              = video_o.tready || !video_o.tvalid;
    assign window_i.tready = en;
    assign accept          = window_i.tvalid && en;
    assign coef_load       = accept && window_i.tuser;

    // A tuser beat sees the coefficients it is loading; all others use the shadow copy.
    always_comb begin
        for (int t = 0; t < N; t++) begin
            coef_sel[t] = coef_load ? CW'(signed'(coef_i[t*COEF_WIDTH +: COEF_WIDTH])) : coef_q[t];
        end
    end

    // Coefficient shadow register, reset to the identity kernel.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int t = 0; t < N; t++) coef_q[t] <= '0;
            coef_q[CTR] <= COEF_ONE;
        end else if (coef_load) begin
            for (int t = 0; t < N; t++) coef_q[t] <= coef_sel[t];
        end
    end

    // Stage 1: zero-extended component times signed coefficient, per component and tap.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < COMP_CNT; c++)
                for (int t = 0; t < N; t++) prod_q[c][t] <= '0;
        end else if (en) begin
            for (int c = 0; c < COMP_CNT; c++)
                for (int t = 0; t < N; t++)
                    prod_q[c][t] <= PROD_W'(signed'({1'b0, window_i.tdata[t*PX_WIDTH + c*COMP_WIDTH +: COMP_WIDTH]}))
                                    * PROD_W'(coef_sel[t]);
        end
    end

    // Adder tree: one registered pairwise level per stage; an odd last node passes through.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < COMP_CNT; c++)
                for (int k = 0; k < TREE_NODES; k++) node_q[c][k] <= '0;
        end else if (en) begin
            for (int c = 0; c < COMP_CNT; c++) begin
                for (int i = 0; i < N; i++) begin
                    if (i < lvl_cnt(1)) begin
                        node_q[c][i] <= ACC_W'(prod_q[c][2*i])
                                      + ((2*i + 1 < N) ? ACC_W'(prod_q[c][2*i+1]) : '0);
                    end
                end
                for (int l = 2; l <= L; l++) begin
                    for (int i = 0; i < N; i++) begin
                        if (i < lvl_cnt(l)) begin
                            node_q[c][lvl_off(l) + i] <= node_q[c][lvl_off(l-1) + 2*i]
                                + ((2*i + 1 < lvl_cnt(l-1)) ? node_q[c][lvl_off(l-1) + 2*i + 1] : '0);
                        end
                    end
                end
            end
        end
    end

    // Sideband shift registers travelling alongside the data stages.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vld_q  <= '0;
            last_q <= '0;
            user_q <= '0;
        end else if (en) begin
            vld_q  <= {vld_q[L-1:0], accept};
            last_q <= {last_q[L-1:0], window_i.tlast};
            user_q <= {user_q[L-1:0], window_i.tuser};
        end
    end

`ifdef WINDOW_CONV_BYPASS_EN
    // Bypass flag and centre pixel delayed to line up with the tree root.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            byp_q <= '0;
            for (int s = 0; s <= L; s++) ctr_q[s] <= '0;
        end else if (en) begin
            byp_q    <= {byp_q[L-1:0], bypass_i};
            ctr_q[0] <= window_i.tdata[CTR*PX_WIDTH +: PX_WIDTH];
            for (int s = 1; s <= L; s++) ctr_q[s] <= ctr_q[s-1];
        end
    end
`endif

    // Normalise and pack the tree root into the next output word.
    always_comb begin
        out_d = '0;
        for (int c = 0; c < COMP_CNT; c++) begin
            out_d[c*COMP_WIDTH +: COMP_WIDTH] = norm_clamp(node_q[c][ROOT]);
        end
`ifdef WINDOW_CONV_BYPASS_EN
        if (byp_q[L]) out_d = TDATA_WIDTH_O'(ctr_q[L]);
`endif
    end

    // Output register; holds while the sink stalls a valid beat.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            video_o.tvalid <= 1'b0;
            video_o.tlast  <= 1'b0;
            video_o.tuser  <= 1'b0;
            video_o.tdata  <= '0;
        end else if (en) begin
            video_o.tvalid <= vld_q[L];
            video_o.tlast  <= last_q[L];
            video_o.tuser  <= user_q[L];
            video_o.tdata  <= out_d;
        end
    end

endmodule

// File: tb/tb_window_conv.sv
// tb/tb_window_conv.sv - self-checking bench for window_conv
module tb_window_conv;
    localparam int N   = 25;
    localparam int PXW = 30;
    localparam int TDW = 32;

    typedef struct {
        logic [PXW-1:0] ctr;
        logic [PXW-1:0] oth;
        int             cc;
        int             co;
        bit             user;
        bit             last;
        logic [TDW-1:0] exp;
    } vec_t;

    typedef struct {
        logic [TDW-1:0] data;
        logic           last;
        logic           user;
    } exp_t;

    logic           clk;
    logic           rstn;
    logic [N*8-1:0] coef;
    int             checks;
    int             failures;
    int             n_out;
    bit             rand_ready;
    exp_t           sb[$];
    vec_t           vt[9];

    axi4_stream_if #(.DW(N*PXW)) win_if ();
    axi4_stream_if #(.DW(TDW))   vid_if ();

    window_conv #(
        .WIN_SIZE(5), .PX_WIDTH(30), .COMP_WIDTH(10), .COMP_CNT(3),
        .COEF_WIDTH(8), .NORM_SHIFT(8), .TDATA_WIDTH_O(32)
    ) dut (
        .clk_i    (clk),
        .rstn_i   (rstn),
        .coef_i   (coef),
`ifdef WINDOW_CONV_BYPASS_EN
        .bypass_i (1'b0),
`endif
        .window_i (win_if),
        .video_o  (vid_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [PXW-1:0] px(input int c2, input int c1, input int c0);
        return {10'(c2), 10'(c1), 10'(c0)};
    endfunction

    function automatic logic [N*PXW-1:0] mkwin(input logic [PXW-1:0] ctr, input logic [PXW-1:0] oth);
        logic [N*PXW-1:0] w;
        for (int t = 0; t < N; t++) w[t*PXW +: PXW] = (t == 12) ? ctr : oth;
        return w;
    endfunction

    function automatic logic [N*8-1:0] mkcoef(input int cc, input int co);
        logic [N*8-1:0] k;
        for (int t = 0; t < N; t++) k[t*8 +: 8] = (t == 12) ? 8'(cc) : 8'(co);
        return k;
    endfunction

    // Reference: centre tap weight cc, remaining 24 taps weight co.
    function automatic logic [TDW-1:0] model(input logic [PXW-1:0] ctr, input logic [PXW-1:0] oth,
                                             input int cc, input int co);
        logic [TDW-1:0] r;
        int s;
        int q;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            s = cc * int'(ctr[c*10 +: 10]) + 24 * co * int'(oth[c*10 +: 10]);
            q = (s + 128) >>> 8;
            if (q < 0) q = 0;
            if (q > 1023) q = 1023;
            r[c*10 +: 10] = 10'(q);
        end
        return r;
    endfunction

    task automatic send(input logic [N*PXW-1:0] win, input logic [N*8-1:0] cf,
                        input bit user, input bit last, input logic [TDW-1:0] exp);
        bit ok;
        bit done;
        int budget;
        exp_t e;
        done   = 1'b0;
        budget = 0;
        win_if.tdata  = win;
        win_if.tuser  = user;
        win_if.tlast  = last;
        win_if.tvalid = 1'b1;
        coef          = cf;
        while (!done && budget < 1000) begin
            @(negedge clk);
            ok = win_if.tready;
            @(posedge clk);
            #1;
            if (ok) begin
                e.data = exp;
                e.last = last;
                e.user = user;
                sb.push_back(e);
                done = 1'b1;
            end
            budget++;
        end
        win_if.tvalid = 1'b0;
        if (!done) chk("send_timeout", 64'(budget), 64'(0));
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        if (sb.size() != 0) chk({name, "_drain_timeout"}, 64'(sb.size()), 64'(0));
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Output monitor: scoreboard pop on handshake, stall stability, input-ready rule.
    initial begin
        logic [TDW-1:0] held_data;
        logic           held_last;
        logic           held_user;
        bit             was_stalled;
        exp_t           e;
        was_stalled = 1'b0;
        held_data   = '0;
        held_last   = 1'b0;
        held_user   = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (was_stalled) begin
                    chk("stall_hold_data", 64'(vid_if.tdata), 64'(held_data));
                    chk("stall_hold_last", 64'(vid_if.tlast), 64'(held_last));
                    chk("stall_hold_user", 64'(vid_if.tuser), 64'(held_user));
                end
                if (vid_if.tvalid && !vid_if.tready) chk("in_ready_low_when_stalled", 64'(win_if.tready), 64'(0));
                if (vid_if.tvalid && vid_if.tready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 64'(vid_if.tdata), 64'hDEAD_0000_0000_0000);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", 64'(vid_if.tdata), 64'(e.data));
                        chk("out_last", 64'(vid_if.tlast), 64'(e.last));
                        chk("out_user", 64'(vid_if.tuser), 64'(e.user));
                        n_out++;
                    end
                end
                was_stalled = vid_if.tvalid && !vid_if.tready;
                held_data   = vid_if.tdata;
                held_last   = vid_if.tlast;
                held_user   = vid_if.tuser;
            end else begin
                was_stalled = 1'b0;
            end
        end
    end

    // Sink readiness: always ready or pseudo-random, changed just after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            vid_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        logic [PXW-1:0] c;
        logic [PXW-1:0] o;
        int             n0;
        exp_t           e;

        checks        = 0;
        failures      = 0;
        n_out         = 0;
        rand_ready    = 1'b0;
        rstn          = 1'b0;
        coef          = '0;
        win_if.tdata  = '0;
        win_if.tvalid = 1'b0;
        win_if.tlast  = 1'b0;
        win_if.tuser  = 1'b0;
        vid_if.tready = 1'b1;

        vt[0] = '{px(10'h3FF, 10'h155, 10'h001), px(10'h2AA, 10'h0F0, 10'h00F),   5,  7, 1'b0, 1'b0, 32'h3FF5_5401};
        vt[1] = '{px(10'h000, 10'h3FF, 10'h200), px(10'h111, 10'h222, 10'h333),  -3,  9, 1'b0, 1'b0, 32'h000F_FE00};
        vt[2] = '{px(100, 100, 100),             px(100, 100, 100),             10, 10, 1'b1, 1'b0, 32'h0621_8862};
        vt[3] = '{px(100, 100, 100),             px(100, 100, 100),             -1, -1, 1'b0, 1'b0, 32'h0621_8862};
        vt[4] = '{px(500, 500, 500),             px(500, 500, 500),             -1, -1, 1'b1, 1'b0, 32'h0000_0000};
        vt[5] = '{px(1023, 1023, 1023),          px(1023, 1023, 1023),         127, 127, 1'b1, 1'b0, 32'h3FFF_FFFF};
        vt[6] = '{px(400, 7, 2),                 px(1023, 1023, 1023),          64,  0, 1'b1, 1'b0, 32'h0640_0801};
        vt[7] = '{px(1023, 1023, 1023),          px(1023, 10, 0),                0,  1, 1'b1, 1'b0, 32'h0600_0400};
        vt[8] = '{px(1023, 0, 5),                px(0, 4, 0),                   -2,  3, 1'b1, 1'b1, 32'h0000_0400};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tvalid", 64'(vid_if.tvalid), 64'(0));
        chk("reset_tdata",  64'(vid_if.tdata),  64'(0));
        chk("reset_tlast",  64'(vid_if.tlast),  64'(0));
        chk("reset_tuser",  64'(vid_if.tuser),  64'(0));
        chk("reset_in_ready", 64'(win_if.tready), 64'(1));
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Latency with the identity kernel: output on the 7th edge counting the accepting edge.
        win_if.tdata  = mkwin(px(10'h3FF, 10'h155, 10'h001), px(10'h0AA, 10'h055, 10'h3F0));
        win_if.tuser  = 1'b0;
        win_if.tlast  = 1'b0;
        win_if.tvalid = 1'b1;
        coef          = mkcoef(33, -5);
        e.data = 32'h3FF5_5401;
        e.last = 1'b0;
        e.user = 1'b0;
        sb.push_back(e);
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) win_if.tvalid = 1'b0;
            chk($sformatf("latency_tvalid_edge%0d", k), 64'(vid_if.tvalid), 64'(k == 7));
        end
        drain("latency");

        // Table of back-to-back vectors.
        for (int i = 0; i < 9; i++) begin
            send(mkwin(vt[i].ctr, vt[i].oth), mkcoef(vt[i].cc, vt[i].co), vt[i].user, vt[i].last, vt[i].exp);
        end
        drain("table");

        // 64-beat line under random backpressure; kernel latched on the first beat only.
        rand_ready = 1'b1;
        n0 = n_out;
        for (int i = 0; i < 64; i++) begin
            c = px((i*37 + 5) % 1024, (i*91 + 200) % 1024, (i*13 + 700) % 1024);
            o = px($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
            if (i == 0) send(mkwin(c, o), mkcoef(64, 0), 1'b1, 1'b0, model(c, o, 64, 0));
            else        send(mkwin(c, o), mkcoef($urandom_range(0, 255), $urandom_range(0, 255)),
                             1'b0, i == 63, model(c, o, 64, 0));
        end
        drain("backpressure");
        rand_ready = 1'b0;
        chk("backpressure_count", 64'(n_out - n0), 64'(64));

        // Reset with beats in flight and an output pending.
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) begin
            c = px(i*50 + 10, i*20 + 3, 1000 - i*7);
            o = px(i, i + 1, i + 2);
            send(mkwin(c, o), mkcoef(20, 3), 1'b0, 1'b0, model(c, o, 64, 0));
        end
        chk("pre_reset_tvalid", 64'(vid_if.tvalid), 64'(1));
        rstn = 1'b0;
        sb.delete();
        #1;
        chk("reset_flush_tvalid", 64'(vid_if.tvalid), 64'(0));
        chk("reset_flush_tdata",  64'(vid_if.tdata),  64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("post_reset_idle", 64'(vid_if.tvalid), 64'(0));
        c = px(10'h2A5, 10'h0C3, 10'h3FE);
        send(mkwin(c, px(7, 7, 7)), mkcoef(90, 90), 1'b0, 1'b1, 32'(c));
        drain("post_reset_identity");

        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
